// File: rtl/fs_accel_pkg.sv
// Shared types and constants for the feature-map accelerator pooling path.
// Holds the sequencer state encoding and the pooling window geometry.
package fs_accel_pkg;

    localparam int DATA_W      = 8;
    localparam int POOL_K      = 2;
    localparam int POOL_STRIDE = 2;

    localparam logic signed [DATA_W-1:0] MIN_VAL = -8'sd128;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RD,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_e;

endpackage

// File: rtl/fs_accel_pool_feeder_if.sv
// Pooled-result stream: valid/ready handshake from the feeder to the writer.
// The feeder drives through master, the consumer attaches through slave.
interface fs_accel_pool_feeder_if #(
    parameter int DATA_W = 8
) ();

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/fs_accel_pool_addr_gen.sv
// Window address generator: tracks row base, column, row and element
// counters for 2x2 stride-2 windows using adders only.
module fs_accel_pool_addr_gen #(
    parameter int DIM_W  = 6,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic [DIM_W-1:0]  map_w,
    input  logic [DIM_W-1:0]  map_h,
    input  logic [ADDR_W-1:0] mem_base,
    input  logic              step,
    input  logic              next_win,
    input  logic              rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              last_elem,
    output logic              last_win
);
    import fs_accel_pkg::*;

    typedef logic [DIM_W:0] dimx_t;

    // A window at c has a successor only if c + stride + k <= extent.
    localparam dimx_t LOOK = dimx_t'(POOL_STRIDE + POOL_K);

    logic [DIM_W-1:0]  w_q, w_d;
    logic [DIM_W-1:0]  h_q, h_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [1:0]        e_q, e_d;
    logic              last_col;
    logic              last_row;

    assign last_col  = (dimx_t'(col_q) + LOOK) > dimx_t'(w_q);
    assign last_row  = (dimx_t'(row_q) + LOOK) > dimx_t'(h_q);
    assign last_win  = last_col && last_row;
    assign last_elem = &e_q;

    assign mem_addr = rd_en
        ? (row_base_q + ADDR_W'(col_q)
           + (e_q[1] ? ADDR_W'(w_q) : '0)
           + ADDR_W'(e_q[0]))
        : '0;

    always_comb begin
        w_d        = w_q;
        h_d        = h_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        e_d        = e_q;
        if (load) begin
            w_d        = map_w;
            h_d        = map_h;
            row_base_d = mem_base;
            col_d      = '0;
            row_d      = '0;
            e_d        = '0;
        end
        if (step) begin
            e_d = e_q + 2'd1;
        end
        if (next_win) begin
            if (last_col) begin
                col_d      = '0;
                row_d      = row_q + DIM_W'(POOL_STRIDE);
                row_base_d = row_base_q + (ADDR_W'(w_q) << 1);
            end else begin
                col_d = col_q + DIM_W'(POOL_STRIDE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_q        <= '0;
            h_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            e_q        <= '0;
        end else begin
            w_q        <= w_d;
            h_q        <= h_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            e_q        <= e_d;
        end
    end

endmodule

// File: rtl/fs_accel_pool_feeder.sv
// 2x2 stride-2 max-pool window sequencer feeding an external compare unit.
// Define FS_ACCEL_POOL_RELU_EN to clamp negative window maxima to zero.
module fs_accel_pool_feeder #(
    parameter int DATA_W = fs_accel_pkg::DATA_W,
    parameter int DIM_W  = 6,
    parameter int ADDR_W = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic [DIM_W-1:0]        map_w,
    input  logic [DIM_W-1:0]        map_h,
    input  logic [ADDR_W-1:0]       mem_base,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_ren,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [DATA_W-1:0]       cp_di,
    output logic                    cp_enb,
    output logic                    cp_rstn,
    input  logic [DATA_W-1:0]       cp_do,
    fs_accel_pool_feeder_if.master  out_if
);
    import fs_accel_pkg::*;

    state_e            state_q, state_d;
    logic              cp_enb_q, cp_enb_d;
    logic              load;
    logic              step;
    logic              next_win;
    logic              last_elem;
    logic              last_win;
    logic              too_small;
    logic [DATA_W-1:0] pooled;

    assign too_small = (map_w < DIM_W'(POOL_K)) || (map_h < DIM_W'(POOL_K));

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        step     = 1'b0;
        next_win = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = too_small ? S_DONE : S_CLR;
                end
            end
            S_CLR: state_d = S_RD;
            S_RD: begin
                step = 1'b1;
                if (last_elem) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_OUT;
            S_OUT: begin
                if (out_if.out_ready) begin
                    if (last_win) begin
                        state_d = S_DONE;
                    end else begin
                        next_win = 1'b1;
                        state_d  = S_CLR;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read data lands a cycle after the request, so the enable trails it.
    assign cp_enb_d = mem_ren;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cp_enb_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cp_enb_q <= cp_enb_d;
        end
    end

`ifdef FS_ACCEL_POOL_RELU_EN
    assign pooled = cp_do[DATA_W-1] ? '0 : cp_do;
`else
    assign pooled = cp_do;
`endif

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign mem_ren = (state_q == S_RD);
    assign cp_enb  = cp_enb_q;
    assign cp_rstn = resetn && (state_q != S_CLR);
    assign cp_di   = mem_rdata;

    assign out_if.out_valid = (state_q == S_OUT);
    assign out_if.out_data  = (state_q == S_OUT) ? pooled : '0;

    fs_accel_pool_addr_gen #(
        .DIM_W  (DIM_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .resetn    (resetn),
        .load      (load),
        .map_w     (map_w),
        .map_h     (map_h),
        .mem_base  (mem_base),
        .step      (step),
        .next_win  (next_win),
        .rd_en     (mem_ren),
        .mem_addr  (mem_addr),
        .last_elem (last_elem),
        .last_win  (last_win)
    );

endmodule

// File: doc/fs_accel_pool_feeder.md
# fs_accel_pool_feeder

Window sequencer for the max-pooling datapath: reads a signed 8-bit feature map from the accelerator's local buffer and streams each 2x2 window, stride 2, into the compare unit. It drives the compare unit's data, enable and clear, captures the window maximum, and presents it on a valid/ready output stream. It sits between the feature-map buffer read port and the pooled-output writer.

## Interface
Parameters:
- DATA_W, 8, element width (signed two's complement)
- DIM_W, 6, width of runtime map dimensions (max 63)
- ADDR_W, 16, buffer address width

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- start  in  1  begin one pooling pass; sampled only in IDLE
- map_w  in  DIM_W  map width in elements; sampled with start
- map_h  in  DIM_W  map height in rows; sampled with start
- mem_base  in  ADDR_W  address of element (0,0); sampled with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at the end of the pass
- mem_addr  out  ADDR_W  buffer read address
- mem_ren  out  1  buffer read enable; data is valid one cycle later
- mem_rdata  in  DATA_W  buffer read data
- cp_di  out  DATA_W  compare-unit data, equal to mem_rdata
- cp_enb  out  1  compare-unit enable, equal to mem_ren delayed one cycle
- cp_rstn  out  1  compare-unit clear, active-low: resetn AND (state != CLR)
- cp_do  in  DATA_W  compare-unit running maximum
- out_data  out  DATA_W  pooled result
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts; transfer occurs when out_valid && out_ready

## Operation
- States:
  - IDLE
  - CLR: 1 cycle
  - RD: 4 cycles, element counter e = 0..3
  - DRAIN: 1 cycle
  - OUT: held until transfer
  - DONE: 1 cycle
- IDLE + start: latch map_w, map_h and mem_base.
  - If map_w < 2 or map_h < 2, go to DONE.
  - Otherwise go to CLR.
- Output grid is floor(map_w/2) x floor(map_h/2), produced in row-major order. An odd last column or row is never read.
- RD element order for window at (r,c): (r,c), (r,c+1), (r+1,c), (r+1,c+1).
  - mem_addr = row_base + c + (e[1] ? map_w : 0) + e[0].
  - row_base starts at mem_base and advances by 2*map_w per output row.
  - Use incremental adders only; no multiplier.
  - All address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- RD → DRAIN after e = 3.
- DRAIN → OUT: by then cp_do holds the window maximum.
- OUT:
  - out_data comes from cp_do; the compare unit receives no enable while in OUT, so the value is stable.
  - On transfer, go to CLR for the next window, or to DONE after the last window.
- DONE: done = 1, then IDLE.
- start outside IDLE is ignored.

## Timing
- Reset values:
  - state = IDLE.
  - busy, done, mem_ren, cp_enb, out_valid = 0.
  - mem_addr = 0, out_data = 0.
  - cp_rstn = 0 while resetn is low.
- Per window: CLR(1) + RD(4) + DRAIN(1) + OUT(≥1) = 7 cycles minimum. With out_ready held high, out_valid rises every 7 cycles.
- cp_enb is high in RD cycles 1–3 and in DRAIN. The first element's enable lands after the CLR edge has loaded -128 into the compare unit.
- Backpressure: while in OUT with out_ready low, out_valid and out_data hold and mem_ren = 0.
- Reset mid-operation (any state): next cycle all outputs are at their reset values and counters are cleared. No partial result is emitted.
- Degenerate pass: done pulses 2 cycles after start (IDLE→DONE) with no mem_ren ever asserted.

## Configuration
- FS_ACCEL_POOL_RELU_EN:
  - Defined: out_data = (cp_do < 0) ? 0 : cp_do, giving fused ReLU.
  - Undefined: out_data = cp_do unmodified.
- Timing is identical in both builds.

## Structure
- Shared package fs_accel_pkg:
  - state enum (IDLE, CLR, RD, DRAIN, OUT, DONE)
  - DATA_W
  - POOL_K = 2, POOL_STRIDE = 2
  - minimum value constant -128
- One sub-module, fs_accel_pool_addr_gen: owns the row_base, column, row and element counters and mem_addr. It is stepped by the FSM and reports the last-element and last-window flags.

## Test plan
- 4x4 map with values 0..15 row-major, mem_base = 0, out_ready = 1 → out_data 5, 7, 13, 15, out_valid spaced 7 cycles, one done pulse, busy low after.
- 2x2 map, all elements -128:
  - RELU off → -128.
  - FS_ACCEL_POOL_RELU_EN defined → 0.
- 5x3 map → exactly 2 outputs; no mem_addr ever references column 4 or row 2.
- out_ready low for 10 cycles at the first output → out_valid and out_data stable, mem_ren = 0 throughout; the next window starts the cycle after transfer.
- map_w = 1, map_h = 8 → no mem_ren; done 2 cycles after start.
- resetn low for one cycle during RD → next cycle outputs at reset values and cp_rstn was 0; a new start on 4x4 yields 5, 7, 13, 15.
